// File: rtl/demux_frame_loader_if.sv
// Source-side sample handshake for demux_frame_loader: one sample plus its
// target channel per beat. A beat transfers when in_valid && in_ready.
interface demux_frame_loader_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SEL_W  = 6
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [SEL_W-1:0]  in_sel;

  // Sample producer
  modport master (
    output in_valid,
    output in_data,
    output in_sel,
    input  in_ready
  );

  // Frame loader
  modport slave (
    input  in_valid,
    input  in_data,
    input  in_sel,
    output in_ready
  );

endinterface

// File: rtl/demux_frame_loader.sv
// Registered, handshaked 1-to-NUM_CH sample demultiplexer. Fills a bank of
// held channel registers, either in order (internal pointer) or by in_sel,
// flags frame completion and stalls the source until the frame is acked.
module demux_frame_loader #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NUM_CH = 64,
  parameter int unsigned SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     mode,
  input  logic                     frame_ack,
  demux_frame_loader_if.slave      src,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic                     load_done,
  output logic                     err_sel,
  output logic                     busy
);

  typedef enum logic [1:0] {StIdle, StLoad, StFull} state_e;

  state_e             state_q;
  logic [SEL_W-1:0]   ptr_q;
  logic               mode_q;

  logic               accept;
  logic [SEL_W-1:0]   tgt;
  logic               sel_err;
  logic               wr_en;
  logic [NUM_CH-1:0]  wr_onehot;
  logic               frame_full;

  assign src.in_ready = (state_q != StFull) && !clear;
  assign busy         = (state_q != StIdle);

  assign accept  = src.in_valid && src.in_ready;
  // mode_q is frozen outside IDLE, so a frame keeps the mode it started with.
  assign tgt     = mode_q ? src.in_sel : ptr_q;
  assign sel_err = accept && mode_q && (32'(src.in_sel) >= NUM_CH);
  assign wr_en   = accept && !sel_err;

  // Decode the write target into a per-channel write strobe.
  always_comb begin
    wr_onehot = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      wr_onehot[k] = wr_en && (tgt == SEL_W'(k));
    end
  end

  // Rewrites of an already-valid channel cannot complete the frame.
  assign frame_full = &(ch_valid | wr_onehot);

  // Frame FSM, fill pointer, channel bank and registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      mode_q    <= 1'b0;
      out_data  <= '0;
      ch_valid  <= '0;
      load_done <= 1'b0;
      err_sel   <= 1'b0;
    end else if (clear) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      out_data  <= '0;
      ch_valid  <= '0;
      load_done <= 1'b0;
      err_sel   <= 1'b0;
    end else begin
      load_done <= 1'b0;
      err_sel   <= sel_err;
      case (state_q)
        StIdle, StLoad: begin
          if (state_q == StIdle) begin
            mode_q <= mode;
          end
          for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (wr_onehot[k]) begin
              out_data[k*DATA_W +: DATA_W] <= src.in_data;
            end
          end
          ch_valid <= ch_valid | wr_onehot;
          if (wr_en && !mode_q) begin
            ptr_q <= (ptr_q == SEL_W'(NUM_CH - 1)) ? '0 : ptr_q + SEL_W'(1);
          end
          // Bad-select beats leave the state alone, even in IDLE.
          if (wr_en) begin
            if (frame_full) begin
              state_q   <= StFull;
              load_done <= 1'b1;
            end else begin
              state_q <= StLoad;
            end
          end
        end
        StFull: begin
          if (frame_ack) begin
            state_q  <= StIdle;
            ch_valid <= '0;
            ptr_q    <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_frame_loader.sv
// Bench for demux_frame_loader: a 5-channel instance (addressed mode, bad
// selects, mode freeze, async reset, gapped fills) and a 64-channel instance
// (full sequential frame, backpressure, clear). Expected frames and error
// snapshots are queued by the stimulus and popped by monitors on the pulses.
module tb_demux_frame_loader;

  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // 5-channel instance
  logic          a_clear, a_mode, a_ack;
  logic [5*DW-1:0] a_out;
  logic [4:0]    a_cv;
  logic          a_done, a_err, a_busy;
  demux_frame_loader_if #(.DATA_W(DW), .SEL_W(3)) a_if ();

  demux_frame_loader #(.DATA_W(DW), .NUM_CH(5)) u_dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (a_clear),
    .mode      (a_mode),
    .frame_ack (a_ack),
    .src       (a_if),
    .out_data  (a_out),
    .ch_valid  (a_cv),
    .load_done (a_done),
    .err_sel   (a_err),
    .busy      (a_busy)
  );

  // 64-channel instance
  logic            b_clear, b_mode, b_ack;
  logic [64*DW-1:0] b_out;
  logic [63:0]     b_cv;
  logic            b_done, b_err, b_busy;
  demux_frame_loader_if #(.DATA_W(DW), .SEL_W(6)) b_if ();

  demux_frame_loader #(.DATA_W(DW), .NUM_CH(64)) u_dut64 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (b_clear),
    .mode      (b_mode),
    .frame_ack (b_ack),
    .src       (b_if),
    .out_data  (b_out),
    .ch_valid  (b_cv),
    .load_done (b_done),
    .err_sel   (b_err),
    .busy      (b_busy)
  );

  logic [5*DW-1:0]  exp5_q[$];
  logic [5*DW-1:0]  err5_q[$];
  logic [64*DW-1:0] exp64_q[$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_a(input logic [DW-1:0] d, input logic [2:0] s);
    int n;
    n = 0;
    a_if.in_valid = 1'b1;
    a_if.in_data  = d;
    a_if.in_sel   = s;
    #1;
    while (!a_if.in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) check("d5 send timeout in_ready", a_if.in_ready, 1'b1);
    @(posedge clk);
    #1;
    a_if.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [DW-1:0] d);
    int n;
    n = 0;
    b_if.in_valid = 1'b1;
    b_if.in_data  = d;
    b_if.in_sel   = '0;
    #1;
    while (!b_if.in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) check("d64 send timeout in_ready", b_if.in_ready, 1'b1);
    @(posedge clk);
    #1;
    b_if.in_valid = 1'b0;
  endtask

  // Monitor: 5-channel completed frames and bad-select pulses.
  always @(negedge clk) begin
    if (a_done) begin
      if (exp5_q.size() == 0) begin
        check("d5 unexpected load_done", a_done, 1'b0);
      end else begin
        logic [5*DW-1:0] e;
        e = exp5_q.pop_front();
        check("d5 frame out_data", a_out, e);
        check("d5 frame ch_valid", a_cv, 5'h1f);
      end
    end
    if (a_err) begin
      if (err5_q.size() == 0) begin
        check("d5 unexpected err_sel", a_err, 1'b0);
      end else begin
        logic [5*DW-1:0] s;
        s = err5_q.pop_front();
        check("d5 err_sel out_data untouched", a_out, s);
      end
    end
  end

  // Monitor: 64-channel completed frames.
  always @(negedge clk) begin
    if (b_done) begin
      if (exp64_q.size() == 0) begin
        check("d64 unexpected load_done", b_done, 1'b0);
      end else begin
        logic [64*DW-1:0] e;
        e = exp64_q.pop_front();
        for (int k = 0; k < 64; k++) begin
          check($sformatf("d64 frame ch%0d", k), b_out[k*DW +: DW], e[k*DW +: DW]);
        end
        check("d64 frame ch_valid", b_cv, {64{1'b1}});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [64*DW-1:0] e64;
    int gaps[5];
    gaps = '{2, 0, 3, 1, 0};

    rst_n = 1'b0;
    a_clear = 1'b0; a_mode = 1'b0; a_ack = 1'b0;
    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.in_sel = '0;
    b_clear = 1'b0; b_mode = 1'b0; b_ack = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.in_sel = '0;
    #2;

    // Reset state
    check("d5 reset out_data", a_out, '0);
    check("d5 reset ch_valid", a_cv, '0);
    check("d5 reset load_done", a_done, 1'b0);
    check("d5 reset err_sel", a_err, 1'b0);
    check("d5 reset busy", a_busy, 1'b0);
    check("d5 reset in_ready", a_if.in_ready, 1'b1);
    check("d64 reset ch_valid", b_cv, '0);
    check("d64 reset busy", b_busy, 1'b0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    tick(1);

    // 64-channel sequential fill, ch k = k
    for (int k = 0; k < 64; k++) e64[k*DW +: DW] = DW'(k);
    exp64_q.push_back(e64);
    for (int k = 0; k < 64; k++) send_b(DW'(k));
    check("d64 load_done after beat 63", b_done, 1'b1);
    check("d64 in_ready low in FULL", b_if.in_ready, 1'b0);
    check("d64 ch_valid all ones", b_cv, {64{1'b1}});
    tick(1);
    check("d64 load_done single cycle", b_done, 1'b0);

    // Backpressure in FULL, then ack and beat in the same cycle
    b_if.in_valid = 1'b1;
    b_if.in_data  = 16'hBEEF;
    repeat (10) begin
      tick(1);
      check("d64 stall in_ready", b_if.in_ready, 1'b0);
    end
    check("d64 stall ch63 held", b_out[63*DW +: DW], 16'h003F);
    check("d64 stall ch0 held", b_out[0 +: DW], 16'h0000);
    check("d64 stall busy", b_busy, 1'b1);
    b_ack = 1'b1;
    #1;
    check("d64 ack cycle in_ready", b_if.in_ready, 1'b0);
    tick(1);
    b_ack = 1'b0;
    check("d64 after ack ch_valid", b_cv, '0);
    check("d64 after ack busy", b_busy, 1'b0);
    check("d64 after ack in_ready", b_if.in_ready, 1'b1);
    check("d64 after ack ch5 retained", b_out[5*DW +: DW], 16'h0005);
    tick(1);
    b_if.in_valid = 1'b0;
    check("d64 post-ack beat ch_valid", b_cv, 64'h1);
    check("d64 post-ack beat ch0", b_out[0 +: DW], 16'hBEEF);
    check("d64 post-ack ch1 retained", b_out[1*DW +: DW], 16'h0001);

    // Clear mid-frame after 30 beats, with a concurrent beat that is lost
    b_clear = 1'b1;
    tick(1);
    b_clear = 1'b0;
    check("d64 clear out_data zero", b_out == '0, 1'b1);
    for (int k = 0; k < 30; k++) send_b(16'h0100 + DW'(k));
    check("d64 30 beats ch_valid", b_cv, 64'h3FFF_FFFF);
    check("d64 30 beats ch29", b_out[29*DW +: DW], 16'h011D);
    b_clear = 1'b1;
    b_if.in_valid = 1'b1;
    b_if.in_data  = 16'hDEAD;
    #1;
    check("d64 clear cycle in_ready", b_if.in_ready, 1'b0);
    tick(1);
    b_clear = 1'b0;
    b_if.in_valid = 1'b0;
    check("d64 cleared out_data", b_out == '0, 1'b1);
    check("d64 cleared ch_valid", b_cv, '0);
    check("d64 cleared busy", b_busy, 1'b0);
    send_b(16'h0777);
    check("d64 after clear ch_valid", b_cv, 64'h1);
    check("d64 after clear ch0", b_out[0 +: DW], 16'h0777);
    check("d64 after clear ch1", b_out[1*DW +: DW], 16'h0000);
    b_clear = 1'b1;
    tick(1);
    b_clear = 1'b0;

    // Addressed mode: bad select in IDLE leaves state alone
    a_mode = 1'b1;
    tick(2);
    err5_q.push_back('0);
    send_a(16'h5555, 3'd5);
    check("d5 idle bad sel err_sel", a_err, 1'b1);
    check("d5 idle bad sel busy", a_busy, 1'b0);
    check("d5 idle bad sel ch_valid", a_cv, '0);
    tick(1);
    check("d5 err_sel single cycle", a_err, 1'b0);

    // Addressed fill: sel 4,2,2,(7),0,1,3
    exp5_q.push_back({16'h00AA, 16'h00FF, 16'h00CC, 16'h00EE, 16'h00DD});
    send_a(16'h00AA, 3'd4);
    send_a(16'h00BB, 3'd2);
    send_a(16'h00CC, 3'd2);
    check("d5 overwrite ch_valid", a_cv, 5'b10100);
    check("d5 overwrite ch2", a_out[2*DW +: DW], 16'h00CC);
    err5_q.push_back({16'h00AA, 16'h0000, 16'h00CC, 16'h0000, 16'h0000});
    send_a(16'h7777, 3'd7);
    check("d5 load bad sel err_sel", a_err, 1'b1);
    check("d5 load bad sel ch_valid", a_cv, 5'b10100);
    check("d5 load bad sel busy", a_busy, 1'b1);
    send_a(16'h00DD, 3'd0);
    send_a(16'h00EE, 3'd1);
    check("d5 five beats ch_valid", a_cv, 5'b10111);
    check("d5 no early load_done", a_done, 1'b0);
    send_a(16'h00FF, 3'd3);
    check("d5 load_done after 6th beat", a_done, 1'b1);
    check("d5 in_ready low in FULL", a_if.in_ready, 1'b0);
    a_ack = 1'b1;
    tick(1);
    a_ack = 1'b0;
    check("d5 after ack ch_valid", a_cv, '0);
    check("d5 after ack busy", a_busy, 1'b0);
    check("d5 after ack out_data retained", a_out,
          {16'h00AA, 16'h00FF, 16'h00CC, 16'h00EE, 16'h00DD});

    // Sequential fill with mode toggled mid-frame; in_sel is ignored
    a_mode = 1'b0;
    tick(2);
    exp5_q.push_back({16'h0055, 16'h0044, 16'h0033, 16'h0022, 16'h0011});
    send_a(16'h0011, 3'd3);
    send_a(16'h0022, 3'd3);
    a_mode = 1'b1;
    send_a(16'h0033, 3'd3);
    send_a(16'h0044, 3'd3);
    send_a(16'h0055, 3'd3);
    check("d5 mode freeze load_done", a_done, 1'b1);
    a_mode = 1'b0;
    a_ack = 1'b1;
    tick(1);
    a_ack = 1'b0;
    tick(1);

    // Async reset between clock edges mid-frame
    send_a(16'h0A01, 3'd0);
    send_a(16'h0A02, 3'd0);
    check("d5 partial frame busy", a_busy, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("d5 async reset out_data", a_out, '0);
    check("d5 async reset ch_valid", a_cv, '0);
    check("d5 async reset busy", a_busy, 1'b0);
    check("d5 async reset load_done", a_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_a(16'h0099, 3'd4);
    check("d5 post-reset ch_valid", a_cv, 5'b00001);
    check("d5 post-reset ch0", a_out[0 +: DW], 16'h0099);
    a_clear = 1'b1;
    tick(1);
    a_clear = 1'b0;

    // Gapped sequential frame
    exp5_q.push_back({16'h0065, 16'h0064, 16'h0063, 16'h0062, 16'h0061});
    for (int i = 0; i < 5; i++) begin
      send_a(16'h0061 + DW'(i), 3'd0);
      tick(gaps[i]);
    end
    check("d5 gapped seq load_done", a_done, 1'b1);
    a_ack = 1'b1;
    tick(1);
    a_ack = 1'b0;

    // Gapped addressed frame: sel 1,3,1,4,0,2
    a_mode = 1'b1;
    tick(2);
    exp5_q.push_back({16'h0074, 16'h0072, 16'h0076, 16'h0073, 16'h0075});
    send_a(16'h0071, 3'd1); tick(gaps[0]);
    send_a(16'h0072, 3'd3); tick(gaps[1]);
    send_a(16'h0073, 3'd1); tick(gaps[2]);
    send_a(16'h0074, 3'd4); tick(gaps[3]);
    send_a(16'h0075, 3'd0);
    check("d5 gapped addr ch_valid", a_cv, 5'b11011);
    send_a(16'h0076, 3'd2);
    check("d5 gapped addr load_done", a_done, 1'b1);
    a_ack = 1'b1;
    tick(1);
    a_ack = 1'b0;
    tick(2);

    check("d5 frames outstanding", exp5_q.size(), 0);
    check("d5 errors outstanding", err5_q.size(), 0);
    check("d64 frames outstanding", exp64_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
